// File: rtl/reset_monitor_if.sv
// reset_monitor_if: board power/reset pins in, synchronous reset and status out
interface reset_monitor_if;
  logic pwr;
  logic rst;
  logic rst_sync;
  logic ready;
  logic [1:0] state;
  logic fault;
  logic [7:0] fault_cnt;
  modport master (output pwr, rst, input rst_sync, ready, state, fault, fault_cnt);
  modport slave (input pwr, rst, output rst_sync, ready, state, fault, fault_cnt);
endinterface

// File: rtl/reset_monitor.sv
// reset_monitor: debounces power/reset pins, sequences a clean internal reset, counts disorderly power loss
module reset_monitor #(
  parameter bit RESETHL = 1'b0,
  parameter int tDB = 16,
  parameter int tHOLD = 1000
) (
  input logic clk,
  input logic rstn,
  reset_monitor_if.slave bus
);
  localparam int DW = tDB > 1 ? $clog2(tDB) : 1;
  localparam int HW = tHOLD > 1 ? $clog2(tHOLD) : 1;
  localparam logic [1:0] DB_RST = 2'b10;
  typedef enum logic [1:0] {OFF, PWR, HOLD, RUN} state_t;
  state_t state;
  logic rst_a;
  logic [1:0] raw, s1, s2, db;
  logic [DW-1:0] cnt [2];
  logic [HW-1:0] hold_cnt;
  logic fault;
  logic [7:0] fault_cnt;
  assign rst_a = RESETHL ? bus.rst : ~bus.rst;
  assign raw = {rst_a, bus.pwr};
  // bit 0 is the power path, bit 1 the reset-asserted path
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1 <= DB_RST;
      s2 <= DB_RST;
      db <= DB_RST;
      cnt <= '{default: '0};
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(tDB - 1)) begin
          db[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  // power loss wins over every other transition; only HOLD/RUN with reset released is a fault
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= OFF;
      hold_cnt <= '0;
      fault <= 1'b0;
      fault_cnt <= '0;
    end else begin
      fault <= 1'b0;
      hold_cnt <= hold_cnt + 1'b1;
      if (state != OFF && !db[0]) begin
        state <= OFF;
        if ((state == HOLD || state == RUN) && !db[1]) begin
          fault <= 1'b1;
          fault_cnt <= fault_cnt + 8'(fault_cnt != 8'hff);
        end
      end else
        case (state)
          OFF: if (db[0]) state <= PWR;
          PWR: if (!db[1]) begin
            state <= HOLD;
            hold_cnt <= '0;
          end
          HOLD: state <= db[1] ? PWR : hold_cnt == HW'(tHOLD - 1) ? RUN : HOLD;
          default: if (db[1]) state <= PWR;
        endcase
    end
  assign bus.rst_sync = state != RUN;
  assign bus.ready = state == RUN;
  assign bus.state = state;
  assign bus.fault = fault;
  assign bus.fault_cnt = fault_cnt;
endmodule

// File: tb/tb_reset_monitor.sv
// tb_reset_monitor: randomized scenarios checked against a window-based behavioural model
module tb_reset_monitor;
  localparam int TDB = 4;
  localparam int TH = 8;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int tests = 0;
  int fails = 0;
  reset_monitor_if bus ();
  reset_monitor #(.RESETHL(1'b0), .tDB(TDB), .tHOLD(TH)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  int m_state, m_cnt, hs, ne;
  bit m_fault, m_pdb, m_rdb;
  bit ph[$], rh[$], wp[$], wr[$];
  logic [12:0] mod_v, dut_v;
  // debounced value follows the sync output once its last TDB samples all agree
  always @(posedge clk or negedge rstn) begin : model
    int ns;
    bit flt, s2p, s2r, allp, allr;
    if (!rstn) begin
      m_state <= 0; m_fault <= 0; m_cnt <= 0; m_pdb <= 0; m_rdb <= 1; ne <= 0; hs <= 0;
      ph.delete(); rh.delete(); wp.delete(); wr.delete();
      ph.push_back(1'b0); ph.push_back(1'b0); rh.push_back(1'b1); rh.push_back(1'b1);
    end else begin
      s2p = ph.pop_front(); ph.push_back(bus.pwr);
      s2r = rh.pop_front(); rh.push_back(!bus.rst);
      wp.push_back(s2p); wr.push_back(s2r);
      if (wp.size() > TDB) begin void'(wp.pop_front()); void'(wr.pop_front()); end
      allp = wp.size() == TDB; allr = allp;
      foreach (wp[i]) begin allp &= wp[i] == s2p; allr &= wr[i] == s2r; end
      if (allp) m_pdb <= s2p;
      if (allr) m_rdb <= s2r;
      ns = m_state; flt = 0;
      if (m_state != 0 && !m_pdb) begin ns = 0; flt = m_state >= 2 && !m_rdb; end
      else if (m_state == 0) ns = m_pdb ? 1 : 0;
      else if (m_rdb) ns = 1;
      else if (m_state == 1) begin ns = 2; hs <= ne; end
      else if (m_state == 2 && ne - hs == TH) ns = 3;
      m_state <= ns;
      m_fault <= flt;
      if (flt && m_cnt < 255) m_cnt <= m_cnt + 1;
      ne <= ne + 1;
    end
  end
  always_comb begin
    mod_v = {m_state == 3, m_state != 3, 2'(m_state), m_fault, 8'(m_cnt)};
    dut_v = {bus.ready, bus.rst_sync, bus.state, bus.fault, bus.fault_cnt};
  end
  task automatic at_edge(int k);
    while (ne < k) @(negedge clk);
  endtask
  task automatic test_reset;
    bus.pwr = 1'b0; bus.rst = 1'b0;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (dut_v !== 13'b0_1_00_0_00000000) begin fails++; $display("FAIL reset: got %b expected %b", dut_v, 13'b0_1_00_0_00000000); end
    tests++; if (dut_v !== mod_v) begin fails++; $display("FAIL reset_model: got %b expected %b", dut_v, mod_v); end
    rstn = 1'b1;
  endtask
  task automatic test_power_up;
    at_edge(10); bus.pwr = 1'b1;
    at_edge(16); tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL pwr_early: got %0d expected 0", bus.state); end
    at_edge(17); tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL pwr_state: got %0d expected 1", bus.state); end
    tests++; if (dut_v !== mod_v) begin fails++; $display("FAIL pwr_model: got %b expected %b", dut_v, mod_v); end
    at_edge(30); bus.rst = 1'b1;
    at_edge(36); tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL hold_early: got %0d expected 1", bus.state); end
    at_edge(37); tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL hold_state: got %0d expected 2", bus.state); end
    at_edge(44); tests++; if (bus.state !== 2'd2) begin fails++; $display("FAIL run_early: got %0d expected 2", bus.state); end
    at_edge(45); tests++; if ({bus.ready, bus.rst_sync, bus.state} !== 4'b1011) begin fails++; $display("FAIL run_state: got %b expected 1011", {bus.ready, bus.rst_sync, bus.state}); end
    tests++; if (dut_v !== mod_v) begin fails++; $display("FAIL run_model: got %b expected %b", dut_v, mod_v); end
  endtask
  task automatic test_glitch;
    for (int p = 0; p < 2; p++) begin
      int len;
      len = $urandom_range(1, TDB - 1);
      if (p == 0) bus.pwr = 1'b0; else bus.rst = 1'b0;
      repeat (len) @(negedge clk);
      bus.pwr = 1'b1; bus.rst = 1'b1;
      repeat (14) begin
        @(negedge clk);
        tests++; if (bus.state !== 2'd3 || bus.fault !== 1'b0) begin fails++; $display("FAIL glitch%0d: got state %0d fault %0d expected 3 0", p, bus.state, bus.fault); end
        tests++; if (dut_v !== mod_v) begin fails++; $display("FAIL glitch_model: got %b expected %b", dut_v, mod_v); end
      end
    end
  endtask
  task automatic test_disorderly;
    int pulses = 0;
    bus.pwr = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      pulses += int'(bus.fault);
      if (i == 6) begin tests++; if (bus.state !== 2'd3) begin fails++; $display("FAIL loss_early: got %0d expected 3", bus.state); end end
      if (i == 7) begin tests++; if (bus.state !== 2'd0 || bus.fault !== 1'b1) begin fails++; $display("FAIL loss_edge: got state %0d fault %0d expected 0 1", bus.state, bus.fault); end end
      tests++; if (dut_v !== mod_v) begin fails++; $display("FAIL loss_model: got %b expected %b", dut_v, mod_v); end
    end
    tests++; if (pulses != 1 || bus.fault_cnt !== 8'd1) begin fails++; $display("FAIL loss_count: got pulses %0d cnt %0d expected 1 1", pulses, bus.fault_cnt); end
  endtask
  task automatic test_recover;
    bus.pwr = 1'b1; bus.rst = 1'b1;
    for (int i = 0; i < 80 && bus.state !== 2'd3; i++) @(negedge clk);
    tests++; if (bus.state !== 2'd3 || dut_v !== mod_v) begin fails++; $display("FAIL recover: got %b expected %b in RUN", dut_v, mod_v); end
  endtask
  task automatic test_orderly;
    bit seen_pwr = 0;
    int pulses = 0;
    bus.rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) bus.pwr = 1'b0;
      @(negedge clk);
      seen_pwr |= bus.state === 2'd1;
      pulses += int'(bus.fault);
      tests++; if (dut_v !== mod_v) begin fails++; $display("FAIL orderly_model: got %b expected %b", dut_v, mod_v); end
    end
    tests++; if (!seen_pwr || bus.state !== 2'd0 || pulses != 0 || bus.fault_cnt !== 8'd1) begin fails++; $display("FAIL orderly: got pwr_seen %0d state %0d pulses %0d cnt %0d expected 1 0 0 1", seen_pwr, bus.state, pulses, bus.fault_cnt); end
  endtask
  task automatic test_simultaneous;
    bit seen_pwr = 0;
    int pulses = 0;
    bus.pwr = 1'b0; bus.rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      seen_pwr |= bus.state === 2'd1;
      pulses += int'(bus.fault);
      if (i == 7) begin tests++; if (bus.state !== 2'd0) begin fails++; $display("FAIL simul_edge: got %0d expected 0", bus.state); end end
      tests++; if (dut_v !== mod_v) begin fails++; $display("FAIL simul_model: got %b expected %b", dut_v, mod_v); end
    end
    tests++; if (seen_pwr || pulses != 0 || bus.fault_cnt !== 8'd1) begin fails++; $display("FAIL simul: got pwr_seen %0d pulses %0d cnt %0d expected 0 0 1", seen_pwr, pulses, bus.fault_cnt); end
  endtask
  task automatic test_hold_abort;
    int w;
    bit seen_hold = 0, seen_run = 0;
    bus.pwr = 1'b1;
    for (int i = 0; i < 40 && bus.state !== 2'd1; i++) @(negedge clk);
    tests++; if (bus.state !== 2'd1) begin fails++; $display("FAIL abort_pwr: got %0d expected 1", bus.state); end
    w = $urandom_range(TDB, TDB + 2);
    bus.rst = 1'b1;
    repeat (w) @(negedge clk);
    bus.rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen_hold |= bus.state === 2'd2;
      seen_run |= bus.state === 2'd3;
      tests++; if (dut_v !== mod_v) begin fails++; $display("FAIL abort_model: got %b expected %b", dut_v, mod_v); end
    end
    tests++; if (!seen_hold || seen_run || bus.state !== 2'd1) begin fails++; $display("FAIL abort: got hold %0d run %0d state %0d expected 1 0 1", seen_hold, seen_run, bus.state); end
  endtask
  task automatic test_saturation;
    int pulses = 0, last = 0;
    for (int n = 0; n < 260; n++) begin
      bus.pwr = 1'b1; bus.rst = 1'b1;
      for (int i = 0; i < 80 && bus.state !== 2'd3; i++) begin @(negedge clk); pulses += int'(bus.fault); end
      bus.pwr = 1'b0;
      last = pulses;
      for (int i = 0; i < 80 && bus.state !== 2'd0; i++) begin @(negedge clk); pulses += int'(bus.fault); end
      last = pulses - last;
      tests++; if (dut_v !== mod_v) begin fails++; $display("FAIL sat_model%0d: got %b expected %b", n, dut_v, mod_v); end
    end
    tests++; if (bus.fault_cnt !== 8'd255 || pulses != 260 || last != 1) begin fails++; $display("FAIL saturate: got cnt %0d pulses %0d last %0d expected 255 260 1", bus.fault_cnt, pulses, last); end
  endtask
  task automatic test_async_reset;
    int pulses = 0, exp_s;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    tests++; if ({bus.state, bus.rst_sync, bus.ready, bus.fault_cnt} !== {2'd0, 1'b1, 1'b0, 8'd0}) begin fails++; $display("FAIL async: got %b expected 0010_00000000", {bus.state, bus.rst_sync, bus.ready, bus.fault_cnt}); end
    tests++; if (dut_v !== mod_v) begin fails++; $display("FAIL async_model: got %b expected %b", dut_v, mod_v); end
    @(negedge clk);
    rstn = 1'b1;
    while (ne < 17) begin
      @(negedge clk);
      pulses += int'(bus.fault);
      exp_s = ne <= 6 ? 0 : ne == 7 ? 1 : ne <= 15 ? 2 : 3;
      tests++; if (bus.state !== 2'(exp_s) || dut_v !== mod_v) begin fails++; $display("FAIL reacquire@%0d: got %0d expected %0d", ne, bus.state, exp_s); end
    end
    tests++; if (pulses != 0 || bus.fault_cnt !== 8'd0) begin fails++; $display("FAIL async_fault: got pulses %0d cnt %0d expected 0 0", pulses, bus.fault_cnt); end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_disorderly();
    test_recover();
    test_orderly();
    test_recover();
    test_simultaneous();
    test_hold_abort();
    test_saturation();
    test_recover();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
